fsm_monitor: RTL and testbench



---
 rtl/fsm_monitor_pkg.sv | 27 ++
 rtl/fsm_monitor_timer.sv | 50 +++++
 rtl/fsm_monitor.sv | 132 +++++++++++++
 tb/tb_fsm_monitor.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fsm_monitor_pkg.sv
// ============================================================================
//  Module      : fsm_monitor_pkg
//  Description : Shared state encoding for the sequencer monitor. Any block
//                that decodes monitor state imports this package.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fsm_monitor_pkg;

  localparam int MON_ST_W = 2;

  localparam logic [MON_ST_W-1:0] MON_IDLE   = 2'd0;
  localparam logic [MON_ST_W-1:0] MON_ACTIVE = 2'd1;
  localparam logic [MON_ST_W-1:0] MON_REPORT = 2'd2;
  localparam logic [MON_ST_W-1:0] MON_ERR    = 2'd3;

  typedef enum logic [MON_ST_W-1:0] {
    ST_IDLE   = MON_IDLE,
    ST_ACTIVE = MON_ACTIVE,
    ST_REPORT = MON_REPORT,
    ST_ERR    = MON_ERR
  } mon_state_e;

endpackage

`default_nettype wire

// File: rtl/fsm_monitor_timer.sv
// ============================================================================
//  Module      : fsm_monitor_timer
//  Description : 8-bit stall timer for the ACTIVE phase. Cleared by start,
//                counts while run is high, flags expired once the count
//                reaches TIMEOUT-1 (the monitor then leaves ACTIVE on the
//                following edge). Only built when FSM_MONITOR_TIMEOUT_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_monitor_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam logic [7:0] c_LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign expired = run && (cnt_q == c_LIMIT);

  // Next count: clear on entry, advance while running, hold at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = 8'd0;
    end else if (run && !expired) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fsm_monitor.sv
// ============================================================================
//  Module      : fsm_monitor
//  Description : Checks that every sequencer done follows a ctl, reports each
//                completed round over valid/ready with a running count, and
//                raises a sticky error on protocol violations until clr.
//                Optional stall timeout enabled by FSM_MONITOR_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_monitor
  import fsm_monitor_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctl,
  input  logic             done,
  input  logic             rdy,
  input  logic             clr,
  output logic             vld,
  output logic [CNT_W-1:0] rounds,
  output logic             busy,
  output logic             err
);

  mon_state_e       state_q;
  logic             vld_q;
  logic [CNT_W-1:0] rounds_q;
  logic             busy_q;
  logic             err_q;
  logic             w_expired;

`ifdef FSM_MONITOR_TIMEOUT_EN
  logic w_start;
  logic w_run;

  // Timer restarts on every transition into ACTIVE (from IDLE or back-to-back)
  assign w_start = ((state_q == ST_IDLE)   && !done && ctl) ||
                   ((state_q == ST_REPORT) && rdy   && ctl);
  assign w_run   = (state_q == ST_ACTIVE);

  fsm_monitor_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (w_start),
    .run     (w_run),
    .expired (w_expired)
  );
`else
  logic [7:0] w_unused_timeout;

  // Without the timer ACTIVE waits indefinitely for done
  assign w_unused_timeout = 8'(TIMEOUT);
  assign w_expired        = 1'b0;
`endif

  assign vld    = vld_q;
  assign rounds = rounds_q;
  assign busy   = busy_q;
  assign err    = err_q;

  // Monitor state machine with registered outputs; vld never looks at rdy
  // combinationally, it only falls on the transfer edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      vld_q    <= 1'b0;
      rounds_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (done) begin
            state_q <= ST_ERR;
            err_q   <= 1'b1;
          end else if (ctl) begin
            state_q <= ST_ACTIVE;
            busy_q  <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          // done wins over a timer expiry on the same edge
          if (done) begin
            state_q  <= ST_REPORT;
            rounds_q <= rounds_q + 1'b1;
            vld_q    <= 1'b1;
            busy_q   <= 1'b0;
          end else if (w_expired) begin
            state_q <= ST_ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_REPORT: begin
          if (rdy) begin
            vld_q <= 1'b0;
            if (ctl) begin
              state_q <= ST_ACTIVE;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (ctl || done) begin
            // overrun or stray done: the pending report is dropped
            state_q <= ST_ERR;
            vld_q   <= 1'b0;
            err_q   <= 1'b1;
          end
        end
        ST_ERR: begin
          // strobes ignored; the count survives clr
          if (clr) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fsm_monitor.sv
// ============================================================================
//  Module      : tb_fsm_monitor
//  Description : Directed self-checking bench for fsm_monitor. Instance u_dut
//                uses CNT_W=8, u_dut2 uses CNT_W=2 for counter wrap; both
//                share stimulus and use TIMEOUT=4. The timeout section
//                follows FSM_MONITOR_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_monitor;

  logic       clk = 1'b0;
  logic       rst, ctl, done, rdy, clr;
  logic       vld, busy, err;
  logic [7:0] rounds;
  logic       vld2, busy2, err2;
  logic [1:0] rounds2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fsm_monitor #(.CNT_W(8), .TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst), .ctl(ctl), .done(done), .rdy(rdy), .clr(clr),
    .vld(vld), .rounds(rounds), .busy(busy), .err(err)
  );

  fsm_monitor #(.CNT_W(2), .TIMEOUT(4)) u_dut2 (
    .clk(clk), .rst(rst), .ctl(ctl), .done(done), .rdy(rdy), .clr(clr),
    .vld(vld2), .rounds(rounds2), .busy(busy2), .err(err2)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic [7:0] er,
                            input logic eb, input logic ee);
    check({tag, ".vld"},    8'(vld),  8'(ev));
    check({tag, ".rounds"}, rounds,   er);
    check({tag, ".busy"},   8'(busy), 8'(eb));
    check({tag, ".err"},    8'(err),  8'(ee));
  endtask

  task automatic drive(input logic c, input logic d, input logic r, input logic k);
    ctl  = c;
    done = d;
    rdy  = r;
    clr  = k;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 3-cycle sequencer round with the consumer always ready
  task automatic nominal_round(input string tag, input logic [7:0] n);
    drive(1'b1, 1'b0, 1'b1, 1'b0); tick();
    expect_out({tag, ".go"}, 1'b0, n - 8'd1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0); tick();
    expect_out({tag, ".rep"}, 1'b1, n, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0); tick();
    expect_out({tag, ".idle"}, 1'b0, n, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    expect_out("reset", 1'b0, 8'd0, 1'b0, 1'b0);
    check("reset.rounds2", 8'(rounds2), 8'd0);
    rst = 1'b0;

    // Nominal cadence: four rounds, one report every 3 cycles
    nominal_round("nom1", 8'd1);
    nominal_round("nom2", 8'd2);
    nominal_round("nom3", 8'd3);
    nominal_round("nom4", 8'd4);

    // Backpressure: report held for 5 cycles, then one transfer
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    expect_out("bp.go", 1'b0, 8'd4, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0); tick();
    expect_out("bp.rep", 1'b1, 8'd5, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out($sformatf("bp.hold%0d", i), 1'b1, 8'd5, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0); tick();
    expect_out("bp.xfer", 1'b0, 8'd5, 1'b0, 1'b0);

    // Back-to-back: transfer and new ctl in the same REPORT cycle
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    expect_out("b2b.go", 1'b0, 8'd5, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0); tick();
    expect_out("b2b.rep1", 1'b1, 8'd6, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0); tick();
    expect_out("b2b.go2", 1'b0, 8'd6, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0); tick();
    expect_out("b2b.rep2", 1'b1, 8'd7, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0); tick();
    expect_out("b2b.idle", 1'b0, 8'd7, 1'b0, 1'b0);

    // done in IDLE, then clr and recovery
    drive(1'b0, 1'b1, 1'b1, 1'b0); tick();
    expect_out("idle_done.err", 1'b0, 8'd7, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1); tick();
    expect_out("idle_done.clr", 1'b0, 8'd7, 1'b0, 1'b0);
    nominal_round("rec1", 8'd8);

    // Overrun: ctl in REPORT with rdy low
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0); tick();
    expect_out("ovr.rep", 1'b1, 8'd9, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    expect_out("ovr.err", 1'b0, 8'd9, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
    expect_out("ovr.ignore", 1'b0, 8'd9, 1'b0, 1'b1);
    // ctl in the clr cycle is ignored
    drive(1'b1, 1'b0, 1'b0, 1'b1); tick();
    expect_out("ovr.clr", 1'b0, 8'd9, 1'b0, 1'b0);
    nominal_round("rec2", 8'd10);

    // Counter wrap on the 2-bit instance
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("rst2", 1'b0, 8'd0, 1'b0, 1'b0);
    check("rst2.rounds2", 8'(rounds2), 8'd0);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b1, 1'b0); tick();
      check($sformatf("wrap%0d.rounds", i),  rounds,         8'(i));
      check($sformatf("wrap%0d.rounds2", i), 8'(rounds2),    8'(i % 4));
      check($sformatf("wrap%0d.vld2", i),    8'(vld2),       8'd1);
      drive(1'b0, 1'b0, 1'b1, 1'b0); tick();
    end

    // Reset while a report is pending
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0); tick();
    expect_out("mid.rep", 1'b1, 8'd6, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("mid.rst", 1'b0, 8'd0, 1'b0, 1'b0);
    check("mid.rst.vld2",    8'(vld2),    8'd0);
    check("mid.rst.rounds2", 8'(rounds2), 8'd0);
    rst = 1'b0;

    // Stall in ACTIVE
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    expect_out("to.go", 1'b0, 8'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FSM_MONITOR_TIMEOUT_EN
    for (int i = 1; i <= 3; i++) begin
      tick();
      expect_out($sformatf("to.wait%0d", i), 1'b0, 8'd0, 1'b1, 1'b0);
    end
    tick();
    expect_out("to.expire", 1'b0, 8'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1); tick();
    expect_out("to.clr", 1'b0, 8'd0, 1'b0, 1'b0);
    nominal_round("to.rec", 8'd1);
`else
    for (int i = 0; i < 100; i++) tick();
    expect_out("nto.wait", 1'b0, 8'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0); tick();
    expect_out("nto.rep", 1'b1, 8'd1, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
